i2c_master_byte: RTL

- Synthesizable single-master I2C byte-level initiator. It is the initiator end for the I2C responder bus-functional model on the same open-drain (triand) bus.
- Accepts START / STOP / WRITE / READ commands over a valid/ready handshake, generates SCL and SDA with open-drain semantics, and returns one response per command.
- Sits between the system-bus command logic and the I2C pins.

---
 rtl/i2c_master_byte.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_byte.sv
// i2c_master_byte
// Purpose: single-master I2C byte-level initiator. Takes START / STOP / WRITE /
// READ_ACK / READ_NAK commands over a valid/ready handshake, drives SCL/SDA as
// open-drain (0 = pull low, 1 = release) and returns one response per command.
// Ports:
//   clk_i, rst_n_i        system clock, asynchronous active-low reset
//   cmd_valid_i/ready_o   command handshake; cmd_i selects the command,
//                         wdata_i is the byte for WRITE (sampled at accept)
//   rsp_valid_o           one-cycle response pulse, with rsp_nak_o (WRITE not
//                         acknowledged) and rsp_err_o (illegal/out-of-sequence)
//   rdata_o               last byte received by a READ
//   busy_o                bus owned (START done, STOP not yet complete)
//   scl_i/sda_i           sensed bus lines
//   scl_o/sda_o           open-drain line drives
module i2c_master_byte #(
    parameter int I2C_DATA_WIDTH = 8,
    parameter int CLK_DIV        = 25
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [2:0]                cmd_i,
    input  logic [I2C_DATA_WIDTH-1:0] wdata_i,
    output logic                      rsp_valid_o,
    output logic                      rsp_nak_o,
    output logic                      rsp_err_o,
    output logic [I2C_DATA_WIDTH-1:0] rdata_o,
    output logic                      busy_o,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_o,
    output logic                      sda_o
);

    localparam int W  = I2C_DATA_WIDTH;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(W + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    // Slot index W is the ACK slot; W-1 is the last data slot.
    localparam logic [BW-1:0] SLOT_ACK  = BW'(W);
    localparam logic [BW-1:0] SLOT_LAST_DATA = BW'(W - 1);

    localparam logic [2:0] CMD_START    = 3'd0;
    localparam logic [2:0] CMD_STOP     = 3'd1;
    localparam logic [2:0] CMD_WRITE    = 3'd2;
    localparam logic [2:0] CMD_READ_ACK = 3'd3;
    localparam logic [2:0] CMD_READ_NAK = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_START,
        ST_STOP,
        ST_WRITE,
        ST_READ
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      quarter;
    logic [BW-1:0]   slot;
    logic [W-1:0]    shift;
    logic            read_ack;
    logic            nak_seen;
    logic            stretch;
    logic            tick;
    logic            cmd_legal;

    // A responder holding SCL low while we release it freezes the quarter timer.
    assign stretch = scl_o & ~scl_i;
    assign tick    = (state != ST_IDLE) && (state != ST_HOLD) && !stretch && (cnt == CNT_LAST);

    // START is legal anywhere (repeated start from HOLD); everything else needs
    // the bus to be owned already. Codes 5-7 are never legal.
    assign cmd_legal = (cmd_i == CMD_START) ||
                       ((state == ST_HOLD) &&
                        ((cmd_i == CMD_STOP) || (cmd_i == CMD_WRITE) ||
                         (cmd_i == CMD_READ_ACK) || (cmd_i == CMD_READ_NAK)));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            quarter     <= '0;
            slot        <= '0;
            shift       <= '0;
            read_ack    <= 1'b0;
            nak_seen    <= 1'b0;
            scl_o       <= 1'b1;
            sda_o       <= 1'b1;
            cmd_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_nak_o   <= 1'b0;
            rsp_err_o   <= 1'b0;
            rdata_o     <= '0;
            busy_o      <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            rsp_nak_o   <= 1'b0;
            rsp_err_o   <= 1'b0;
            case (state)
                ST_IDLE, ST_HOLD: begin
                    cnt     <= '0;
                    quarter <= '0;
                    // Ready drops for one cycle after an error response.
                    if (!cmd_ready_o) begin
                        cmd_ready_o <= 1'b1;
                    end else if (cmd_valid_i) begin
                        cmd_ready_o <= 1'b0;
                        if (!cmd_legal) begin
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                        end else begin
                            case (cmd_i)
                                CMD_START: begin
                                    // From IDLE skip the (sda=1,scl=0) quarter.
                                    state   <= ST_START;
                                    scl_o   <= (state == ST_IDLE);
                                    sda_o   <= 1'b1;
                                    quarter <= (state == ST_IDLE) ? 2'd1 : 2'd0;
                                end
                                CMD_STOP: begin
                                    state <= ST_STOP;
                                    scl_o <= 1'b0;
                                    sda_o <= 1'b0;
                                end
                                CMD_WRITE: begin
                                    state    <= ST_WRITE;
                                    slot     <= '0;
                                    shift    <= wdata_i;
                                    nak_seen <= 1'b0;
                                    scl_o    <= 1'b0;
                                    sda_o    <= wdata_i[W-1];
                                end
                                CMD_READ_ACK, CMD_READ_NAK: begin
                                    state    <= ST_READ;
                                    slot     <= '0;
                                    read_ack <= (cmd_i == CMD_READ_ACK);
                                    scl_o    <= 1'b0;
                                    sda_o    <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                default: begin
                    if (!stretch) begin
                        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                    end
                    if (tick) begin
                        quarter <= quarter + 2'd1;
                        case (state)
                            ST_START: begin
                                case (quarter)
                                    2'd0: scl_o <= 1'b1;
                                    2'd1: sda_o <= 1'b0;
                                    2'd2: scl_o <= 1'b0;
                                    default: begin
                                        state       <= ST_HOLD;
                                        busy_o      <= 1'b1;
                                        rsp_valid_o <= 1'b1;
                                        cmd_ready_o <= 1'b1;
                                    end
                                endcase
                            end
                            ST_STOP: begin
                                // Last quarter keeps both lines released as bus-free time.
                                case (quarter)
                                    2'd0: scl_o <= 1'b1;
                                    2'd1: sda_o <= 1'b1;
                                    2'd2: ;
                                    default: begin
                                        state       <= ST_IDLE;
                                        busy_o      <= 1'b0;
                                        rsp_valid_o <= 1'b1;
                                        cmd_ready_o <= 1'b1;
                                    end
                                endcase
                            end
                            ST_WRITE, ST_READ: begin
                                case (quarter)
                                    2'd0: scl_o <= 1'b1;
                                    2'd1: ;
                                    2'd2: begin
                                        scl_o <= 1'b0;
                                        if (slot == SLOT_ACK) begin
                                            if (state == ST_WRITE) begin
                                                nak_seen <= sda_i;
                                            end
                                        end else if (state == ST_READ) begin
                                            shift <= {shift[W-2:0], sda_i};
                                        end
                                    end
                                    default: begin
                                        if (slot == SLOT_ACK) begin
                                            state       <= ST_HOLD;
                                            rsp_valid_o <= 1'b1;
                                            cmd_ready_o <= 1'b1;
                                            if (state == ST_WRITE) begin
                                                rsp_nak_o <= nak_seen;
                                            end else begin
                                                rdata_o <= shift;
                                            end
                                        end else begin
                                            // Set up SDA for the next slot while SCL is low.
                                            slot <= slot + 1'b1;
                                            if (state == ST_WRITE) begin
                                                shift <= {shift[W-2:0], 1'b0};
                                                sda_o <= (slot == SLOT_LAST_DATA) ? 1'b1 : shift[W-2];
                                            end else begin
                                                sda_o <= (slot == SLOT_LAST_DATA) ? ~read_ack : 1'b1;
                                            end
                                        end
                                    end
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
